seven_seg_update_ctrl: RTL and testbench

Update controller and arbiter for the 8-digit `seq_seven_seg` display.
- Two requesters (A, B) each offer a full 32-bit hex value plus a per-digit write mask over a valid/ready handshake.
- The block grants one requester round-robin and sequences the masked digits into the display's `write`/`num`/`sel` port, one digit at a time.
- Sits between the system bus/registers and `seq_seven_seg`, and is the only agent driving that port.

---
 rtl/seven_seg_pkg.sv | 14 +
 rtl/seven_seg_update_ctrl_rr_arbiter2.sv | 31 +++
 rtl/seven_seg_update_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seven_seg_update_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Types and constants shared by the seven-segment update controller and display.
package seven_seg_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SETUP,
    ST_STROBE,
    ST_DONE
  } upd_state_e;

endpackage

// File: rtl/seven_seg_update_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer says who wins a tie and only
// moves when the controller finishes an update.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic advance_i,
  input  logic served_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ptr_b_q;

  // Pointer register: after an update, favour the requester that was not served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_b_q <= 1'b0;
    end else if (advance_i) begin
      ptr_b_q <= ~served_b_i;
    end
  end

  // A sole requester always wins; on a tie the pointer decides.
  always_comb begin
    gnt_a_o = req_a_i & (~req_b_i | ~ptr_b_q);
    gnt_b_o = req_b_i & (~req_a_i |  ptr_b_q);
  end

endmodule

// File: rtl/seven_seg_update_ctrl.sv
// Update controller for the seq_seven_seg display: grants one of two
// requesters and writes its masked digits one at a time.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a request; ready is offered to the granted side
// ST_SCAN   | inspect mask[idx]; skip the digit or load num/sel
// ST_SETUP  | hold num/sel stable for HOLD_CYCLES before the strobe
// ST_STROBE | write is high for exactly this one cycle
// ST_DONE   | done pulse, arbiter pointer moves, back to idle
module seven_seg_update_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int HOLD_CYCLES = 1,
  localparam int SEL_W = $clog2(DIGITS),
  localparam int VAL_W = DIGIT_W * DIGITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_valid,
  input  logic [VAL_W-1:0]   a_value,
  input  logic [DIGITS-1:0]  a_mask,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [VAL_W-1:0]   b_value,
  input  logic [DIGITS-1:0]  b_mask,
  output logic               b_ready,
  output logic               write,
  output logic [DIGIT_W-1:0] num,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               done
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(DIGITS - 1);

  upd_state_e                       state_q, state_d;
  logic [DIGITS-1:0][DIGIT_W-1:0]   value_q, value_d;
  logic [DIGITS-1:0]                mask_q, mask_d;
  logic                             served_b_q, served_b_d;
  logic [SEL_W-1:0]                 idx_q, idx_d;
  logic [HOLD_W-1:0]                hold_q, hold_d;
  logic [DIGIT_W-1:0]               num_q, num_d;
  logic [SEL_W-1:0]                 sel_q, sel_d;
  logic                             write_q, write_d;
  logic                             done_q, done_d;
  logic                             gnt_a, gnt_b;
  logic                             advance;
  logic                             last_idx;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_a_i    (a_valid),
    .req_b_i    (b_valid),
    .advance_i  (advance),
    .served_b_i (served_b_q),
    .gnt_a_o    (gnt_a),
    .gnt_b_o    (gnt_b)
  );

  assign last_idx = (idx_q == LAST_IDX);

  // State, datapath and output registers; reset aborts any update in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      mask_q     <= '0;
      served_b_q <= 1'b0;
      idx_q      <= '0;
      hold_q     <= '0;
      num_q      <= '0;
      sel_q      <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      mask_q     <= mask_d;
      served_b_q <= served_b_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      num_q      <= num_d;
      sel_q      <= sel_d;
      write_q    <= write_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath updates for the digit sequencer.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    mask_d     = mask_q;
    served_b_d = served_b_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    num_d      = num_q;
    sel_d      = sel_q;
    advance    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_a || gnt_b) begin
          value_d    = gnt_b ? b_value : a_value;
          mask_d     = gnt_b ? b_mask  : a_mask;
          served_b_d = gnt_b;
          idx_d      = '0;
          state_d    = (mask_d == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (mask_q[idx_q]) begin
          num_d   = value_q[idx_q];
          sel_d   = idx_q;
          hold_d  = HOLD_LOAD;
          state_d = ST_SETUP;
        end else if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SETUP: begin
        if (hold_q == '0) begin
          state_d = ST_STROBE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        advance = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe and done are registered so they line up exactly with their states.
  always_comb begin
    write_d = (state_d == ST_STROBE);
    done_d  = (state_d == ST_DONE);
  end

  assign a_ready = (state_q == ST_IDLE) && gnt_a;
  assign b_ready = (state_q == ST_IDLE) && gnt_b;
  assign busy    = (state_q != ST_IDLE);
  assign write   = write_q;
  assign num     = num_q;
  assign sel     = sel_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seven_seg_update_ctrl.sv
// Bench for seven_seg_update_ctrl: directed table, reset abort, random traffic
// and a HOLD_CYCLES=3 instance.
module tb_seven_seg_update_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] a_value = '0, b_value = '0;
  logic [7:0]  a_mask = '0, b_mask = '0;
  logic        a_ready, b_ready, write, busy, done;
  logic [3:0]  num;
  logic [2:0]  sel;

  logic        h_valid = 1'b0, hb_valid = 1'b0;
  logic [31:0] h_value = '0, hb_value = '0;
  logic [7:0]  h_mask = '0, hb_mask = '0;
  logic        h_ready, hb_ready, h_write, h_busy, h_done;
  logic [3:0]  h_num;
  logic [2:0]  h_sel;

  seven_seg_update_ctrl #(.DIGITS(8), .HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_value(a_value), .a_mask(a_mask), .a_ready(a_ready),
    .b_valid(b_valid), .b_value(b_value), .b_mask(b_mask), .b_ready(b_ready),
    .write(write), .num(num), .sel(sel), .busy(busy), .done(done)
  );

  seven_seg_update_ctrl #(.DIGITS(8), .HOLD_CYCLES(3)) dut_h3 (
    .clk(clk), .reset(reset),
    .a_valid(h_valid), .a_value(h_value), .a_mask(h_mask), .a_ready(h_ready),
    .b_valid(hb_valid), .b_value(hb_value), .b_mask(hb_mask), .b_ready(hb_ready),
    .write(h_write), .num(h_num), .sel(h_sel), .busy(h_busy), .done(h_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endfunction

  typedef struct { int cyc; int sel; int num; } strobe_t;
  strobe_t obs_q[$];
  int      done_q[$];

  // monitor on the falling edge: record strobes/done, check write protocol
  logic       prev_write = 1'b0;
  logic [3:0] prev_num = '0;
  logic [2:0] prev_sel = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_write = 1'b0;
    end else begin
      if (write) obs_q.push_back('{cyc, int'(sel), int'(num)});
      if (done)  done_q.push_back(cyc);
      if (prev_write) chk("write_back_to_back", int'(write), 0);
      if (write || prev_write) begin
        chk("sel_stable_around_strobe", int'(sel), int'(prev_sel));
        chk("num_stable_around_strobe", int'(num), int'(prev_num));
      end
      prev_write = write;
    end
    prev_num = num;
    prev_sel = sel;
  end

  // reference model: timing from the per-digit cycle costs, arbitration from the rules
  strobe_t exp_q[$];
  int      exp_done;
  logic    m_ptr_b;
  int      m_sel, m_num;
  int      last_done;

  function automatic void model_txn(input logic [31:0] v, input logic [7:0] m, input int h);
    int t;
    exp_q.delete();
    t = 0;
    if (m != 8'h00) begin
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          exp_q.push_back('{t + 1 + h, i, int'(v[4*i +: 4])});
          t += 2 + h;
        end else begin
          t += 1;
        end
      end
    end
    exp_done = t;
  endfunction

  task automatic model_reset();
    m_ptr_b   = 1'b0;
    m_sel     = 0;
    m_num     = 0;
    last_done = -1;
  endtask

  task automatic run_and_check(input logic av, input logic [31:0] avl, input logic [7:0] am,
                               input logic bv, input logic [31:0] bvl, input logic [7:0] bm,
                               input string tag, output int win);
    int acc, n, exp_win, nobs;
    exp_win = (av && bv) ? int'(m_ptr_b) : (bv ? 1 : 0);
    win = exp_win;
    obs_q.delete();
    done_q.delete();
    a_valid = av; a_value = avl; a_mask = am;
    b_valid = bv; b_value = bvl; b_mask = bm;
    #1;
    n = 0;
    while (!(a_ready || b_ready) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!(a_ready || b_ready)) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    win = b_ready ? 1 : 0;
    acc = cyc + 1;
    chk({tag, "_winner"}, win, exp_win);
    if (last_done >= 0) chk({tag, "_gap_after_done"}, acc - last_done, 2);
    @(posedge clk); #1;
    if (win == 0) a_valid = 1'b0; else b_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, int'(busy), 1);
    chk({tag, "_ready_one_cycle"}, int'(a_ready | b_ready), 0);
    n = 0;
    while (done_q.size() == 0 && n < 400) begin
      @(negedge clk); #1; n++;
    end
    if (done_q.size() == 0) begin
      chk({tag, "_done_timeout"}, 0, 1);
      return;
    end
    if (win == 0) model_txn(avl, am, 1); else model_txn(bvl, bm, 1);
    chk({tag, "_strobe_count"}, obs_q.size(), exp_q.size());
    nobs = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nobs; i++) begin
      chk($sformatf("%s_strobe%0d_time", tag, i), obs_q[i].cyc - acc, exp_q[i].cyc);
      chk($sformatf("%s_strobe%0d_sel", tag, i), obs_q[i].sel, exp_q[i].sel);
      chk($sformatf("%s_strobe%0d_num", tag, i), obs_q[i].num, exp_q[i].num);
    end
    chk({tag, "_done_time"}, done_q[0] - acc, exp_done);
    if (exp_q.size() > 0) begin
      m_sel = exp_q[exp_q.size()-1].sel;
      m_num = exp_q[exp_q.size()-1].num;
    end
    chk({tag, "_sel_held"}, int'(sel), m_sel);
    chk({tag, "_num_held"}, int'(num), m_num);
    m_ptr_b   = (win == 0);
    last_done = done_q[0];
    @(negedge clk); #1;
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_idle_after_done"}, int'(busy), 0);
  endtask

  typedef struct {
    logic        av; logic [31:0] avl; logic [7:0] am;
    logic        bv; logic [31:0] bvl; logic [7:0] bm;
    int          exp_win; int exp_n; int exp_done;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [7:0] rand_mask();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, acc, n, nw, dcnt, dfirst;
    logic pa, pb;
    logic [31:0] pav, pbv;
    logic [7:0]  pam, pbm;
    int hw[48], hs[48], hn[48], hd[48];

    tbl[0] = '{1'b1, 32'h1111_1111, 8'h03, 1'b1, 32'h2222_2222, 8'h0C, 0, 2, 12};
    tbl[1] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 32'h2222_2222, 8'h0C, 1, 2, 12};
    tbl[2] = '{1'b1, 32'h0000_00C0, 8'h02, 1'b1, 32'h3333_3333, 8'hFF, 0, 1, 10};
    tbl[3] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 32'h3333_3333, 8'hFF, 1, 8, 24};
    tbl[4] = '{1'b1, 32'h5555_5555, 8'h00, 1'b0, 32'h0000_0000, 8'h00, 0, 0, 0};
    tbl[5] = '{1'b1, 32'h8765_4321, 8'hFF, 1'b0, 32'h0000_0000, 8'h00, 0, 8, 24};
    tbl[6] = '{1'b1, 32'hF000_000A, 8'h81, 1'b0, 32'h0000_0000, 8'h00, 0, 2, 12};
    tbl[7] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 32'h9000_0000, 8'h80, 1, 1, 10};

    // reset values
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_write", int'(write), 0);
    chk("rst_num", int'(num), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_a_ready", int'(a_ready), 0);
    chk("rst_b_ready", int'(b_ready), 0);
    reset = 1'b1;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_and_check(tbl[i].av, tbl[i].avl, tbl[i].am, tbl[i].bv, tbl[i].bvl, tbl[i].bm,
                    $sformatf("vec%0d", i), w);
      chk($sformatf("vec%0d_tbl_winner", i), w, tbl[i].exp_win);
      chk($sformatf("vec%0d_tbl_strobes", i), obs_q.size(), tbl[i].exp_n);
      if (done_q.size() > 0) chk($sformatf("vec%0d_tbl_done", i), done_q[0] - (last_done - tbl[i].exp_done), tbl[i].exp_done);
    end

    // reset during the 4th digit's setup aborts the update
    a_valid = 1'b1; a_value = 32'h8765_4321; a_mask = 8'hFF;
    #1;
    n = 0;
    while (!a_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("abort_accept", int'(a_ready), 1);
    acc = cyc + 1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    while (cyc < acc + 10) @(negedge clk);
    #1;
    chk("abort_pre_busy", int'(busy), 1);
    chk("abort_pre_sel", int'(sel), 3);
    chk("abort_pre_num", int'(num), 4);
    reset = 1'b0;
    #1;
    chk("abort_write", int'(write), 0);
    chk("abort_num", int'(num), 0);
    chk("abort_sel", int'(sel), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    obs_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("abort_no_strobe", obs_q.size(), 0);
    chk("abort_stays_idle", int'(busy), 0);
    run_and_check(1'b1, 32'h8765_4321, 8'hFF, 1'b0, 32'h0, 8'h00, "restart", w);

    // random traffic, losers hold their request until granted
    pa = 1'b0; pb = 1'b0; pav = '0; pbv = '0; pam = '0; pbm = '0;
    for (int r = 0; r < 40; r++) begin
      if (!pa && $urandom_range(0, 1) == 1) begin pa = 1'b1; pav = $urandom; pam = rand_mask(); end
      if (!pb && $urandom_range(0, 1) == 1) begin pb = 1'b1; pbv = $urandom; pbm = rand_mask(); end
      if (!pa && !pb) begin pa = 1'b1; pav = $urandom; pam = rand_mask(); end
      run_and_check(pa, pav, pam, pb, pbv, pbm, $sformatf("rnd%0d", r), w);
      if (w == 0) pa = 1'b0; else pb = 1'b0;
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // HOLD_CYCLES=3 instance, full mask
    h_valid = 1'b1; h_value = 32'h8765_4321; h_mask = 8'hFF;
    #1;
    n = 0;
    while (!h_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("h3_accept", int'(h_ready), 1);
    acc = cyc + 1;
    @(posedge clk); #1;
    h_valid = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      hw[k] = int'(h_write); hs[k] = int'(h_sel); hn[k] = int'(h_num); hd[k] = int'(h_done);
    end
    model_txn(32'h8765_4321, 8'hFF, 3);
    nw = 0; dcnt = 0; dfirst = -1;
    for (int k = 0; k < 48; k++) begin
      nw += hw[k];
      dcnt += hd[k];
      if (hd[k] == 1 && dfirst < 0) dfirst = k;
    end
    chk("h3_strobe_count", nw, exp_q.size());
    chk("h3_done_time", dfirst, exp_done);
    chk("h3_done_cycles", dcnt, 1);
    foreach (exp_q[i]) begin
      chk($sformatf("h3_strobe%0d_write", i), hw[exp_q[i].cyc], 1);
      for (int d = 0; d <= 3; d++) begin
        chk($sformatf("h3_strobe%0d_sel_m%0d", i, d), hs[exp_q[i].cyc - d], exp_q[i].sel);
        chk($sformatf("h3_strobe%0d_num_m%0d", i, d), hn[exp_q[i].cyc - d], exp_q[i].num);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
